// File: rtl/conv_seq_pkg.sv
// Shared encodings for the conv layer sequencer and the conv input interface.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_PRELOAD = 2'd1,
    CMD_SHIFT   = 2'd2,
    CMD_LOAD    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ACK_NONE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_SHIFT,
    ST_LOAD,
    ST_DRAIN
  } seq_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_seq_tag_pipe.sv
// Result tag delay line: clear pulse at stage 0, calc_fin plus tags at stage STAGES.
module conv_seq_tag_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] tag_in,
  output logic             clear,
  output logic             calc_fin,
  output logic [TAG_W-1:0] tag_out,
  output logic             empty
);

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][TAG_W-1:0] tag_pipe;

  // Tag stages only load behind a valid entry, so the last stage holds the
  // most recent result tag after calc_fin drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], push};
      if (push) tag_pipe[0] <= tag_in;
      for (int k = 1; k <= STAGES; k++)
        if (vld_pipe[k-1]) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign clear    = vld_pipe[0];
  assign calc_fin = vld_pipe[STAGES];
  assign tag_out  = tag_pipe[STAGES];
  // True when nothing is left after the last stage retires this cycle.
  assign empty    = !push && !(|vld_pipe[STAGES-1:0]);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Frame sequencer for the conv layer: walks feature/column/row through the
// input interface preload/shift/load handshake and tags each kernel result.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_FEATURE  = 4,
  parameter int NUM_SHIFT    = 6,
  parameter int NUM_ROW      = 6,
  parameter int CALC_LATENCY = 2,
  parameter int FEAT_W       = clog2_min1(NUM_FEATURE),
  parameter int COL_W        = clog2_min1(NUM_SHIFT),
  parameter int ROW_W        = clog2_min1(NUM_ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              enable,
  input  logic [1:0]        ack,
  output logic [1:0]        cmd,
  output logic              kernel_array_clear,
  output logic              kernel_calc_fin,
  output logic [FEAT_W-1:0] feature_idx,
  output logic [COL_W-1:0]  col_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              proto_err
);

  localparam int TAG_W = FEAT_W + COL_W + ROW_W;
  localparam logic [FEAT_W-1:0] F_LAST = FEAT_W'(NUM_FEATURE - 1);
  localparam logic [COL_W-1:0]  C_LAST = COL_W'(NUM_SHIFT - 1);
  localparam logic [ROW_W-1:0]  R_LAST = ROW_W'(NUM_ROW - 1);

  seq_state_e        state;
  logic [FEAT_W-1:0] f;
  logic [COL_W-1:0]  c;
  logic [ROW_W-1:0]  r;
  ack_e              ack_in;
  logic              ack_ok;
  logic              shift_fin;
  logic              pipe_empty;
  logic [TAG_W-1:0]  tag_out;

  assign ack_in = ack_e'(ack);

  always_comb begin
    ack_ok = 1'b0;
    case (state)
      ST_PRELOAD: ack_ok = (ack_in == ACK_PRELOAD_FIN);
      ST_SHIFT:   ack_ok = (ack_in == ACK_SHIFT_FIN);
      ST_LOAD:    ack_ok = (ack_in == ACK_LOAD_FIN);
      default:    ack_ok = 1'b0;
    endcase
  end

  assign shift_fin = enable && (state == ST_SHIFT) && (ack_in == ACK_SHIFT_FIN);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      f          <= '0;
      c          <= '0;
      r          <= '0;
      cmd        <= CMD_IDLE;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      cmd        <= CMD_IDLE;
      frame_done <= 1'b0;
      if (enable && ack_in != ACK_NONE && !ack_ok) proto_err <= 1'b1;
      if (enable) begin
        case (state)
          ST_IDLE: if (start) begin
            f         <= '0;
            c         <= '0;
            r         <= '0;
            proto_err <= 1'b0;
            cmd       <= CMD_PRELOAD;
            state     <= ST_PRELOAD;
          end
          ST_PRELOAD: if (ack_in == ACK_PRELOAD_FIN) begin
            cmd   <= CMD_SHIFT;
            state <= ST_SHIFT;
          end
          ST_SHIFT: if (ack_in == ACK_SHIFT_FIN) begin
            if (f < F_LAST) begin
              f   <= f + 1'b1;
              cmd <= CMD_SHIFT;
            end else begin
              f <= '0;
              if (c < C_LAST) begin
                c     <= c + 1'b1;
                cmd   <= CMD_LOAD;
                state <= ST_LOAD;
              end else begin
                c <= '0;
                if (r < R_LAST) begin
                  r     <= r + 1'b1;
                  cmd   <= CMD_PRELOAD;
                  state <= ST_PRELOAD;
                end else begin
                  state <= ST_DRAIN;
                end
              end
            end
          end
          ST_LOAD: if (ack_in == ACK_LOAD_FIN) begin
            cmd   <= CMD_SHIFT;
            state <= ST_SHIFT;
          end
          ST_DRAIN: if (pipe_empty) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  conv_seq_tag_pipe #(
    .STAGES (CALC_LATENCY),
    .TAG_W  (TAG_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (shift_fin),
    .tag_in   ({f, c, r}),
    .clear    (kernel_array_clear),
    .calc_fin (kernel_calc_fin),
    .tag_out  (tag_out),
    .empty    (pipe_empty)
  );

  assign {feature_idx, col_idx, row_idx} = tag_out;

endmodule
